// File: rtl/lms_fir_serial.sv
// ============================================================================
// Module   : lms_fir_serial
// Function : Adaptive LMS FIR filter built around one time-multiplexed MAC,
//            with run-time coefficient load/readback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lms_fir_serial #(
  parameter int DATA_WIDTH  = 16,
  parameter int DATA_FRAC   = 15,
  parameter int COEFF_WIDTH = 16,
  parameter int COEFF_FRAC  = 15,
  parameter int ACC_WIDTH   = 40,
  parameter int TAP_COUNT   = 16,
  parameter int MU_Q        = 164,
  parameter int THRESH_Q    = 1638
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         adapt_en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_x,
  input  logic [DATA_WIDTH-1:0]        in_d,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_y,
  output logic [DATA_WIDTH-1:0]        out_e,
  output logic                         out_adapted,
  output logic                         out_sat,
  input  logic                         coef_we,
  input  logic [$clog2(TAP_COUNT)-1:0] coef_addr,
  input  logic [COEFF_WIDTH-1:0]       coef_wdata,
  output logic [COEFF_WIDTH-1:0]       coef_rdata
);

  localparam int c_aw = $clog2(TAP_COUNT);
  localparam int c_cw = $clog2(TAP_COUNT + 1);
  localparam int c_pw = COEFF_WIDTH + DATA_WIDTH;
  localparam int c_gw = 2 * DATA_WIDTH;
  localparam int c_sw = ((c_gw > COEFF_WIDTH) ? c_gw : COEFF_WIDTH) + 1;
  localparam logic signed [DATA_WIDTH-1:0] c_mu  = DATA_WIDTH'(MU_Q);
  localparam logic [DATA_WIDTH-1:0]        c_dmax = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0]        c_dmin = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [COEFF_WIDTH-1:0]       c_cmax = {1'b0, {(COEFF_WIDTH-1){1'b1}}};
  localparam logic [COEFF_WIDTH-1:0]       c_cmin = {1'b1, {(COEFF_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_ERR, S_UPD, S_OUT} state_t;

  state_t                        r_state;
  logic signed [DATA_WIDTH-1:0]  r_x    [TAP_COUNT];
  logic signed [COEFF_WIDTH-1:0] r_coef [TAP_COUNT];
  logic signed [DATA_WIDTH-1:0]  r_d;
  logic                          r_adapt_en;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic signed [c_pw-1:0]        r_prod;
  logic signed [DATA_WIDTH-1:0]  r_g;
  logic [c_cw-1:0]               r_cnt;

  logic [c_aw-1:0]               w_k;
  logic                          w_addr_ok;
  logic signed [c_pw-1:0]        w_mprod;
  logic [ACC_WIDTH-COEFF_FRAC-DATA_WIDTH:0] w_yhi;
  logic                          w_yovf;
  logic signed [DATA_WIDTH-1:0]  w_y;
  logic signed [DATA_WIDTH:0]    w_ediff;
  logic                          w_eovf;
  logic signed [DATA_WIDTH-1:0]  w_e;
  logic [DATA_WIDTH:0]           w_eabs;
  logic                          w_adapt;
  logic signed [c_gw-1:0]        w_gprod;
  logic signed [c_gw-1:0]        w_uprod;
  logic signed [c_gw-1:0]        w_ush;
  logic signed [c_sw-1:0]        w_usum;
  logic [c_sw-COEFF_WIDTH:0]     w_uhi;
  logic [COEFF_WIDTH-1:0]        w_usat;

  assign w_k      = r_cnt[c_aw-1:0];
  assign in_ready = (r_state == S_IDLE);

  if ((1 << c_aw) == TAP_COUNT) begin : g_addr_full
    assign w_addr_ok = 1'b1;
  end else begin : g_addr_part
    assign w_addr_ok = (32'(coef_addr) < TAP_COUNT);
  end

  assign w_mprod = c_pw'(r_coef[w_k]) * c_pw'(r_x[w_k]);

  // y = floor(acc / 2^COEFF_FRAC), clamped when the discarded high bits are not pure sign
  assign w_yhi  = r_acc[ACC_WIDTH-1:COEFF_FRAC+DATA_WIDTH-1];
  assign w_yovf = !((&w_yhi) || !(|w_yhi));
  assign w_y    = w_yovf ? (r_acc[ACC_WIDTH-1] ? c_dmin : c_dmax)
                         : r_acc[COEFF_FRAC +: DATA_WIDTH];

  assign w_ediff = {r_d[DATA_WIDTH-1], r_d} - {w_y[DATA_WIDTH-1], w_y};
  assign w_eovf  = w_ediff[DATA_WIDTH] ^ w_ediff[DATA_WIDTH-1];
  assign w_e     = w_eovf ? (w_ediff[DATA_WIDTH] ? c_dmin : c_dmax)
                          : w_ediff[DATA_WIDTH-1:0];

  // One extra bit so the most negative error yields a positive magnitude
  assign w_eabs  = w_e[DATA_WIDTH-1] ? -{w_e[DATA_WIDTH-1], w_e} : {1'b0, w_e};
  assign w_adapt = r_adapt_en && (w_eabs >= (DATA_WIDTH+1)'(THRESH_Q));
  assign w_gprod = c_gw'(c_mu) * c_gw'(w_e);

  assign w_uprod = c_gw'(r_g) * c_gw'(r_x[w_k]);
  assign w_ush   = w_uprod >>> DATA_FRAC;
  assign w_usum  = c_sw'(w_ush) + c_sw'(r_coef[w_k]);
  assign w_uhi   = w_usum[c_sw-1:COEFF_WIDTH-1];
  assign w_usat  = ((&w_uhi) || !(|w_uhi)) ? w_usum[COEFF_WIDTH-1:0]
                 : (w_usum[c_sw-1] ? c_cmin : c_cmax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_d         <= '0;
      r_adapt_en  <= 1'b0;
      r_acc       <= '0;
      r_prod      <= '0;
      r_g         <= '0;
      r_cnt       <= '0;
      out_valid   <= 1'b0;
      out_y       <= '0;
      out_e       <= '0;
      out_adapted <= 1'b0;
      out_sat     <= 1'b0;
      for (int i = 0; i < TAP_COUNT; i++) begin
        r_x[i]    <= '0;
        r_coef[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x[0] <= in_x;
            for (int i = 1; i < TAP_COUNT; i++) r_x[i] <= r_x[i-1];
            r_d        <= in_d;
            r_adapt_en <= adapt_en;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_state    <= S_MAC;
          end else if (coef_we && w_addr_ok) begin
            r_coef[coef_addr] <= coef_wdata;
          end
        end
        // Product is registered, so the accumulate trails the multiply by one cycle
        S_MAC: begin
          if (r_cnt != c_cw'(TAP_COUNT)) r_prod <= w_mprod;
          if (r_cnt != '0) r_acc <= r_acc + ACC_WIDTH'(r_prod);
          if (r_cnt == c_cw'(TAP_COUNT)) r_state <= S_ERR;
          else r_cnt <= r_cnt + 1'b1;
        end
        S_ERR: begin
          out_y       <= w_y;
          out_e       <= w_e;
          out_sat     <= w_yovf || w_eovf;
          out_adapted <= w_adapt;
          r_g         <= w_gprod[DATA_FRAC +: DATA_WIDTH];
          r_cnt       <= '0;
          if (w_adapt) begin
            r_state <= S_UPD;
          end else begin
            out_valid <= 1'b1;
            r_state   <= S_OUT;
          end
        end
        S_UPD: begin
          r_coef[w_k] <= w_usat;
          if (r_cnt == c_cw'(TAP_COUNT - 1)) begin
            out_valid <= 1'b1;
            r_state   <= S_OUT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) coef_rdata <= '0;
    else     coef_rdata <= w_addr_ok ? r_coef[coef_addr] : '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_lms_fir_serial.sv
// ============================================================================
// Module   : tb_lms_fir_serial
// Function : Directed self-checking bench for lms_fir_serial.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lms_fir_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        adapt_en = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = '0;
  logic [15:0] in_d = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_y;
  logic [15:0] out_e;
  logic        out_adapted;
  logic        out_sat;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = '0;
  logic [15:0] coef_wdata = '0;
  logic [15:0] coef_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  lms_fir_serial dut (
    .clk(clk), .rst(rst), .adapt_en(adapt_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_d(in_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_e(out_e),
    .out_adapted(out_adapted), .out_sat(out_sat),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_rdata(coef_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_coef(input int a, input int v);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 4'(a); coef_wdata = 16'(v);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic read_coef(input int a, output logic [15:0] v);
    @(negedge clk);
    coef_addr = 4'(a);
    @(negedge clk);
    v = coef_rdata;
  endtask

  // Returns clock edges from the accept edge until out_valid is seen (bounded)
  task automatic send(input int x, input int d, input logic ad, output int lat);
    @(negedge clk);
    in_x = 16'(x); in_d = 16'(d); adapt_en = ad; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_y !== 16'h0000) begin n_fail++; $display("FAIL reset_out_y: got %h want 0000", out_y); end
    n_checks++; if (out_e !== 16'h0000) begin n_fail++; $display("FAIL reset_out_e: got %h want 0000", out_e); end
    n_checks++; if (coef_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h want 0000", coef_rdata); end
  endtask

  task automatic test_basic();
    int lat;
    logic [15:0] rd;
    do_reset();
    write_coef(0, 16384);
    read_coef(0, rd);
    n_checks++; if (rd !== 16'd16384) begin n_fail++; $display("FAIL basic_wr_rd: got %h want 4000", rd); end
    send(16384, 0, 1'b0, lat);
    n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL basic_latency: got %0d want 18", lat); end
    n_checks++; if (out_y !== 16'(8192)) begin n_fail++; $display("FAIL basic_y: got %h want 2000", out_y); end
    n_checks++; if (out_e !== 16'(-8192)) begin n_fail++; $display("FAIL basic_e: got %h want e000", out_e); end
    n_checks++; if (out_adapted !== 1'b0) begin n_fail++; $display("FAIL basic_adapted: got %b want 0", out_adapted); end
    n_checks++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL basic_sat: got %b want 0", out_sat); end
    release_out();
    read_coef(0, rd);
    n_checks++; if (rd !== 16'd16384) begin n_fail++; $display("FAIL basic_w0_kept: got %h want 4000", rd); end
  endtask

  task automatic test_backpressure();
    int lat;
    do_reset();
    write_coef(0, 16384);
    send(8192, 1000, 1'b0, lat);
    n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL bp_latency: got %0d want 18", lat); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold c%0d: got %b want 1", c, out_valid); end
      n_checks++; if (out_y !== 16'(4096)) begin n_fail++; $display("FAIL bp_y_hold c%0d: got %h want 1000", c, out_y); end
      n_checks++; if (out_e !== 16'(-3096)) begin n_fail++; $display("FAIL bp_e_hold c%0d: got %h want f3e8", c, out_e); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, in_ready); end
    end
    release_out();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %b want 1", in_ready); end
  endtask

  task automatic test_adapt();
    int lat;
    logic [15:0] rd;
    do_reset();
    send(32767, 16384, 1'b1, lat);
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL adapt_latency: got %0d want 34", lat); end
    n_checks++; if (out_y !== 16'h0000) begin n_fail++; $display("FAIL adapt_y: got %h want 0000", out_y); end
    n_checks++; if (out_e !== 16'(16384)) begin n_fail++; $display("FAIL adapt_e: got %h want 4000", out_e); end
    n_checks++; if (out_adapted !== 1'b1) begin n_fail++; $display("FAIL adapt_flag: got %b want 1", out_adapted); end
    release_out();
    read_coef(0, rd);
    n_checks++; if (rd !== 16'd81) begin n_fail++; $display("FAIL adapt_w0: got %0d want 81", rd); end
    read_coef(1, rd);
    n_checks++; if (rd !== 16'd0) begin n_fail++; $display("FAIL adapt_w1: got %0d want 0", rd); end
    read_coef(15, rd);
    n_checks++; if (rd !== 16'd0) begin n_fail++; $display("FAIL adapt_w15: got %0d want 0", rd); end
  endtask

  task automatic test_threshold();
    int lat;
    logic [15:0] rd;
    do_reset();
    write_coef(0, 16384);
    send(2000, 2000, 1'b1, lat);
    n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL thr_below_latency: got %0d want 18", lat); end
    n_checks++; if (out_y !== 16'(1000)) begin n_fail++; $display("FAIL thr_below_y: got %0d want 1000", out_y); end
    n_checks++; if (out_e !== 16'(1000)) begin n_fail++; $display("FAIL thr_below_e: got %0d want 1000", out_e); end
    n_checks++; if (out_adapted !== 1'b0) begin n_fail++; $display("FAIL thr_below_flag: got %b want 0", out_adapted); end
    release_out();
    read_coef(0, rd);
    n_checks++; if (rd !== 16'd16384) begin n_fail++; $display("FAIL thr_below_w0: got %0d want 16384", rd); end
    // |e| exactly at threshold adapts; g = floor(-8.2) = -9, w1 += floor(-0.55) = -1
    send(0, -1638, 1'b1, lat);
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL thr_edge_latency: got %0d want 34", lat); end
    n_checks++; if (out_e !== 16'(-1638)) begin n_fail++; $display("FAIL thr_edge_e: got %h want f99a", out_e); end
    n_checks++; if (out_adapted !== 1'b1) begin n_fail++; $display("FAIL thr_edge_flag: got %b want 1", out_adapted); end
    release_out();
    read_coef(1, rd);
    n_checks++; if (rd !== 16'hFFFF) begin n_fail++; $display("FAIL thr_edge_w1_floor: got %h want ffff", rd); end
    read_coef(0, rd);
    n_checks++; if (rd !== 16'd16384) begin n_fail++; $display("FAIL thr_edge_w0: got %0d want 16384", rd); end
  endtask

  task automatic test_saturation();
    int lat;
    do_reset();
    write_coef(0, 32767);
    write_coef(1, 32767);
    send(32767, -32768, 1'b0, lat);
    n_checks++; if (out_y !== 16'(32766)) begin n_fail++; $display("FAIL sat1_y: got %0d want 32766", out_y); end
    n_checks++; if (out_e !== 16'h8000) begin n_fail++; $display("FAIL sat1_e: got %h want 8000", out_e); end
    n_checks++; if (out_sat !== 1'b1) begin n_fail++; $display("FAIL sat1_flag: got %b want 1", out_sat); end
    release_out();
    send(32767, -32768, 1'b0, lat);
    n_checks++; if (out_y !== 16'h7FFF) begin n_fail++; $display("FAIL sat2_y: got %h want 7fff", out_y); end
    n_checks++; if (out_e !== 16'h8000) begin n_fail++; $display("FAIL sat2_e: got %h want 8000", out_e); end
    n_checks++; if (out_sat !== 1'b1) begin n_fail++; $display("FAIL sat2_flag: got %b want 1", out_sat); end
    release_out();
  endtask

  task automatic test_reset_midop();
    int lat;
    logic [15:0] rd;
    do_reset();
    write_coef(0, 16384);
    @(negedge clk);
    in_x = 16'd16384; in_d = 16'd0; adapt_en = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (24) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    read_coef(0, rd);
    n_checks++; if (rd !== 16'd0) begin n_fail++; $display("FAIL midrst_w0: got %0d want 0", rd); end
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 4'd2; coef_wdata = 16'd1234;
    in_x = 16'd0; in_d = 16'd0; adapt_en = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    coef_we = 1'b0; in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL collide_accepted: in_ready %b want 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL collide_latency: got %0d want 18", lat); end
    release_out();
    read_coef(2, rd);
    n_checks++; if (rd !== 16'd0) begin n_fail++; $display("FAIL collide_w2_dropped: got %0d want 0", rd); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_adapt();
    test_threshold();
    test_saturation();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
